// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: mult/div FSM encoding,
// default mult/div latency and register-number width.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned RegW         = 5;
  localparam int unsigned MdLatDefault = 32;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/pipe_md_seq.sv
// Mult/div sequencer: issues a one-cycle start pulse and holds md_busy for exactly
// MD_LAT cycles using a down-counter.
module pipe_md_seq
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_LAT = MdLatDefault,
  parameter int unsigned CNT_W  = 6
) (
  input  logic clk,
  input  logic clrn,
  input  logic start,
  output logic md_go,
  output logic md_busy
);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (start) begin
            r_state <= MD_BUSY;
            r_cnt   <= CNT_W'(MD_LAT - 1);
          end
        end
        MD_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= MD_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  // Gating with clrn keeps the pulse low while reset is held, even with start asserted.
  assign md_go   = clrn & (r_state == MD_IDLE) & start;
  assign md_busy = (r_state == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, mult/div interlock and
// branch flush. Define HAZARD_STATS_EN to add stat_lu/stat_md/stat_br cycle counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_LAT = MdLatDefault,
  parameter int unsigned CNT_W  = 6
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [RegW-1:0] id_rs,
  input  logic [RegW-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_md_start,
  input  logic            id_md_read,
  input  logic            idexe_m2reg,
  input  logic            idexe_regw,
  input  logic [RegW-1:0] idexe_regrd,
  input  logic            exe_branch_taken,
  output logic            wpcir,
  output logic            idexe_bubble,
  output logic            ifid_flush,
  output logic            md_go,
  output logic            md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     stat_lu,
  output logic [31:0]     stat_md,
  output logic [31:0]     stat_br
`endif
);

  logic w_lu;
  logic w_mdi;
  logic w_stall;
  logic w_md_start;

  assign w_lu = idexe_m2reg & idexe_regw & (idexe_regrd != '0) &
                ((id_use_rs & (id_rs == idexe_regrd)) | (id_use_rt & (id_rt == idexe_regrd)));

  assign w_mdi   = md_busy & (id_md_start | id_md_read);
  assign w_stall = (w_lu | w_mdi) & ~exe_branch_taken;

  // A wrong-path or load-stalled mult/div must not start the unit.
  assign w_md_start = id_md_start & ~w_lu & ~exe_branch_taken;

  pipe_md_seq #(
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) u_md_seq (
    .clk     (clk),
    .clrn    (clrn),
    .start   (w_md_start),
    .md_go   (md_go),
    .md_busy (md_busy)
  );

  assign wpcir        = clrn & ~w_stall;
  assign idexe_bubble = ~clrn | w_stall | exe_branch_taken;
  assign ifid_flush   = ~clrn | exe_branch_taken;

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stat_lu;
  logic [31:0] r_stat_md;
  logic [31:0] r_stat_br;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_stat_lu <= '0;
      r_stat_md <= '0;
      r_stat_br <= '0;
    end else begin
      if (w_lu & ~exe_branch_taken)  r_stat_lu <= r_stat_lu + 32'd1;
      if (w_mdi & ~exe_branch_taken) r_stat_md <= r_stat_md + 32'd1;
      if (exe_branch_taken)          r_stat_br <= r_stat_br + 32'd1;
    end
  end

  assign stat_lu = r_stat_lu;
  assign stat_md = r_stat_md;
  assign stat_br = r_stat_br;
`endif

endmodule
